// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: shared widths, FSM state, loop-count and address-stream types
package loop_seq_pkg;
  localparam int LS_AW = 32;
  localparam int LS_CW = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [LS_CW-1:0] c0;
    logic [LS_CW-1:0] c1;
    logic [LS_CW-1:0] c2;
  } cnt_t;
  typedef struct packed {
    logic [LS_AW-1:0] base;
    logic [LS_AW-1:0] s0;
    logic [LS_AW-1:0] s1;
    logic [LS_AW-1:0] s2;
  } stream_t;
endpackage

// File: rtl/loop_seq_ctrl_if.sv
// loop_seq_ctrl_if: beat stream to the datapath (valid/ready/last/wa/ia; master drives beats, slave drives ready)
interface loop_seq_ctrl_if
  import loop_seq_pkg::*;
#(parameter int AW = LS_AW);
  logic valid;
  logic ready;
  logic last;
  logic [AW-1:0] wa;
  logic [AW-1:0] ia;
  modport master(output valid, last, wa, ia, input ready);
  modport slave(input valid, last, wa, ia, output ready);
endinterface

// File: rtl/loop_addr_acc.sv
// loop_addr_acc: cur/row/pln accumulator for one address stream (in: clk, rst, load, step, wrap0, wrap1, cfg; out: cur)
module loop_addr_acc
  import loop_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             wrap0,
  input  logic             wrap1,
  input  stream_t          cfg,
  output logic [LS_AW-1:0] cur
);
  logic [LS_AW-1:0] s0, s1, s2, row, pln, nrow;
  always_comb nrow = wrap1 ? pln + s2 : row + s1;
  always_ff @(posedge clk)
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      cur <= '0;
      row <= '0;
      pln <= '0;
    end else if (load) begin
      s0 <= cfg.s0;
      s1 <= cfg.s1;
      s2 <= cfg.s2;
      cur <= cfg.base;
      row <= cfg.base;
      pln <= cfg.base;
    end else if (step) begin
      pln <= wrap1 ? nrow : pln;
      row <= wrap0 ? nrow : row;
      cur <= wrap0 ? nrow : cur + s0;
    end
endmodule

// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: 3-level nested loop address sequencer (in: clk, rst, start, cnt0-2, wa/ia base+strides; out: run, done, bus beats)
module loop_seq_ctrl
  import loop_seq_pkg::*;
#(
  parameter int AW = LS_AW,
  parameter int CW = LS_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cnt0,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  input  logic [AW-1:0] wa_base,
  input  logic [AW-1:0] wa_s0,
  input  logic [AW-1:0] wa_s1,
  input  logic [AW-1:0] wa_s2,
  input  logic [AW-1:0] ia_base,
  input  logic [AW-1:0] ia_s0,
  input  logic [AW-1:0] ia_s1,
  input  logic [AW-1:0] ia_s2,
  output logic          run,
  output logic          done,
  loop_seq_ctrl_if.master bus
);
  state_t state;
  cnt_t c;
  stream_t wcfg, icfg;
  logic [CW-1:0] k0, k1, k2, nk0, nk1, nk2;
  logic [AW-1:0] wa_q, ia_q;
  logic hs, w0, w1, fin, nlast, nz, load, step;
  always_comb begin
    hs = bus.valid & bus.ready;
    w0 = k0 == c.c0 - CW'(1);
    w1 = w0 & (k1 == c.c1 - CW'(1));
    fin = w1 & (k2 == c.c2 - CW'(1));
    nk0 = w0 ? '0 : k0 + CW'(1);
    nk1 = w1 ? '0 : w0 ? k1 + CW'(1) : k1;
    nk2 = w1 ? k2 + CW'(1) : k2;
    nlast = (nk0 == c.c0 - CW'(1)) & (nk1 == c.c1 - CW'(1)) & (nk2 == c.c2 - CW'(1));
    nz = (|cnt0) & (|cnt1) & (|cnt2);
    load = (state == IDLE) & start & nz;
    step = hs & ~fin;
    wcfg = '{base: wa_base, s0: wa_s0, s1: wa_s1, s2: wa_s2};
    icfg = '{base: ia_base, s0: ia_s0, s1: ia_s1, s2: ia_s2};
  end
  loop_addr_acc u_wa (
    .clk(clk), .rst(rst), .load(load), .step(step), .wrap0(w0), .wrap1(w1), .cfg(wcfg), .cur(wa_q)
  );
  loop_addr_acc u_ia (
    .clk(clk), .rst(rst), .load(load), .step(step), .wrap0(w0), .wrap1(w1), .cfg(icfg), .cur(ia_q)
  );
  assign bus.wa = wa_q;
  assign bus.ia = ia_q;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      c <= '0;
      k0 <= '0;
      k1 <= '0;
      k2 <= '0;
      run <= 1'b0;
      done <= 1'b0;
      bus.valid <= 1'b0;
      bus.last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c <= '{c0: cnt0, c1: cnt1, c2: cnt2};
          k0 <= '0;
          k1 <= '0;
          k2 <= '0;
          state <= nz ? RUN : DONE;
          run <= nz;
          bus.valid <= nz;
          bus.last <= (cnt0 == CW'(1)) & (cnt1 == CW'(1)) & (cnt2 == CW'(1));
          done <= ~nz;
        end
        RUN: if (hs) begin
          k0 <= nk0;
          k1 <= nk1;
          k2 <= nk2;
          state <= fin ? DONE : RUN;
          run <= ~fin;
          bus.valid <= ~fin;
          bus.last <= ~fin & nlast;
          done <= fin;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
